// File: rtl/sorted_chunk_serializer.sv
// sorted_chunk_serializer
//
// Buffers the sorted wide chunks that the mergesort network produces in a small chunk FIFO.
// Each chunk is replayed as a stream of single records, smallest key first, over a
// valid/ready handshake. The network cannot be stalled. Upstream throttling therefore relies
// on the exported free-entry count, and any chunk that arrives while the FIFO is full is
// dropped and flagged.
//
// Ports:
//   CLK      clock, all state on rising edge
//   RST      asynchronous active-high reset
//   DIN      sorted chunk, record r at bits [DATW*(r+1)-1:DATW*r], r=0 smallest
//   DINEN    DIN valid this cycle (single-cycle pulse per chunk, no backpressure)
//   DOT      current output record
//   DOTEN    DOT valid
//   DOTLAST  DOT is the last record of its chunk
//   RDY      downstream accepts DOT this cycle
//   FREE     number of empty FIFO entries
//   OVF      sticky: at least one chunk dropped since reset

module sorted_chunk_serializer #(
  parameter int unsigned P_LOG = 4,
  parameter int unsigned DATW  = 64,
  parameter int unsigned KEYW  = 32,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNTW  = 3
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [(DATW<<P_LOG)-1:0] DIN,
  input  logic                     DINEN,
  output logic [DATW-1:0]          DOT,
  output logic                     DOTEN,
  output logic                     DOTLAST,
  input  logic                     RDY,
  output logic [CNTW-1:0]          FREE,
  output logic                     OVF
);

  localparam int unsigned CHUNKW = DATW << P_LOG;
  localparam int unsigned PTRW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [CHUNKW-1:0] mem_q [DEPTH];
  logic [PTRW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CNTW-1:0]   count_q;
  logic [P_LOG-1:0]  idx_q;
  logic              ovf_q;

  logic              full, last, xfer, pop, accept;
  logic [CHUNKW-1:0] head;

  assign full   = (count_q == CNTW'(DEPTH));
  assign last   = (idx_q == '1);
  assign DOTEN  = (count_q != '0);
  assign xfer   = DOTEN & RDY;
  assign pop    = xfer & last;
  // A full FIFO still takes a chunk when its head leaves on the same edge.
  assign accept = DINEN & (~full | pop);

  assign DOTLAST = DOTEN & last;
  assign FREE    = CNTW'(DEPTH) - count_q;
  assign OVF     = ovf_q;

  // Output record is a plain mux of the registered head entry; no extra pipeline stage.
  always_comb begin
    head = mem_q[rd_ptr_q];
    DOT  = head[DATW*idx_q +: DATW];
  end

  // The key field is carried through untouched; nothing in this block compares it.
  logic [KEYW-1:0] key_unused;
  assign key_unused = DOT[KEYW-1:0];

  // Storage is deliberately left out of reset.
  always_ff @(posedge CLK) begin
    if (accept) begin
      mem_q[wr_ptr_q] <= DIN;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      idx_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (accept) begin
        wr_ptr_q <= wr_ptr_q + PTRW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTRW'(1);
      end
      // idx wraps to zero naturally on the last record of a chunk.
      if (xfer) begin
        idx_q <= idx_q + P_LOG'(1);
      end
      if (accept && !pop) begin
        count_q <= count_q + CNTW'(1);
      end else if (pop && !accept) begin
        count_q <= count_q - CNTW'(1);
      end
      if (DINEN && !accept) begin
        ovf_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sorted_chunk_serializer.sv
module tb_sorted_chunk_serializer;

  localparam int unsigned P_LOG = 2;
  localparam int unsigned DATW  = 8;
  localparam int unsigned KEYW  = 4;
  localparam int unsigned DEPTH = 2;
  localparam int unsigned CNTW  = 2;

  logic        CLK = 1'b0;
  logic        RST;
  logic [31:0] DIN;
  logic        DINEN;
  logic [7:0]  DOT;
  logic        DOTEN;
  logic        DOTLAST;
  logic        RDY;
  logic [1:0]  FREE;
  logic        OVF;

  int checks = 0;
  int errors = 0;

  // Scoreboard entries: {last, record}
  logic [8:0] sb [$];

  sorted_chunk_serializer #(
    .P_LOG (P_LOG),
    .DATW  (DATW),
    .KEYW  (KEYW),
    .DEPTH (DEPTH),
    .CNTW  (CNTW)
  ) dut (
    .CLK     (CLK),
    .RST     (RST),
    .DIN     (DIN),
    .DINEN   (DINEN),
    .DOT     (DOT),
    .DOTEN   (DOTEN),
    .DOTLAST (DOTLAST),
    .RDY     (RDY),
    .FREE    (FREE),
    .OVF     (OVF)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Expected records of a chunk the DUT is supposed to accept.
  task automatic expect_chunk(input logic [31:0] c);
    for (int r = 0; r < 4; r++) begin
      sb.push_back({(r == 3), c[8*r +: 8]});
    end
  endtask

  // Monitor: every transfer must match the head of the scoreboard.
  always @(negedge CLK) begin
    if (!RST && DOTEN && RDY) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_record: got %0h, expected none", DOT);
      end else begin
        logic [8:0] e;
        e = sb.pop_front();
        chk("stream_dot", {24'd0, DOT}, {24'd0, e[7:0]});
        chk("stream_last", {31'd0, DOTLAST}, {31'd0, e[8]});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  int exp_free [9] = '{1, 0, 0, 0, 1, 1, 1, 1, 2};

  initial begin
    RST = 1'b1; DIN = '0; DINEN = 1'b0; RDY = 1'b0;
    tick(); tick();
    RST = 1'b0;

    // 1. Dirty the state (full, overflowed, mid-chunk), then reset mid-cycle
    DINEN = 1'b1;
    DIN = 32'h04030201; expect_chunk(DIN); tick();
    DIN = 32'h08070605; expect_chunk(DIN); tick();
    DIN = 32'h0c0b0a09; tick();
    DINEN = 1'b0;
    RDY = 1'b1; tick();
    RDY = 1'b0;
    chk("pre_reset_ovf", {31'd0, OVF}, 32'd1);
    chk("pre_reset_free", {30'd0, FREE}, 32'd0);
    #2 RST = 1'b1;
    #1;
    chk("reset_doten", {31'd0, DOTEN}, 32'd0);
    chk("reset_dotlast", {31'd0, DOTLAST}, 32'd0);
    chk("reset_free", {30'd0, FREE}, 32'd2);
    chk("reset_ovf", {31'd0, OVF}, 32'd0);
    sb.delete();
    tick();
    RST = 1'b0;
    RDY = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("post_reset_idle", {31'd0, DOTEN}, 32'd0);
    end

    // 2. Single chunk, RDY held high
    DIN = 32'h40302010; DINEN = 1'b1; expect_chunk(DIN); tick();
    DINEN = 1'b0;
    chk("single_latency_doten", {31'd0, DOTEN}, 32'd1);
    chk("single_first_dot", {24'd0, DOT}, 32'h10);
    chk("single_free", {30'd0, FREE}, 32'd1);
    repeat (4) tick();
    chk("single_done_doten", {31'd0, DOTEN}, 32'd0);
    chk("single_done_free", {30'd0, FREE}, 32'd2);

    // 3. Backpressure after the second record
    DINEN = 1'b1; expect_chunk(DIN); tick();
    DINEN = 1'b0;
    tick();
    RDY = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("stall_dot", {24'd0, DOT}, 32'h20);
      chk("stall_doten", {31'd0, DOTEN}, 32'd1);
      chk("stall_dotlast", {31'd0, DOTLAST}, 32'd0);
      tick();
    end
    chk("stall_end_dot", {24'd0, DOT}, 32'h20);
    RDY = 1'b1;
    repeat (3) tick();
    chk("stall_done_doten", {31'd0, DOTEN}, 32'd0);

    // 4. Back-to-back chunks
    for (int i = 0; i < 9; i++) begin
      if (i == 0) begin
        DIN = 32'h44332211; DINEN = 1'b1; expect_chunk(DIN);
      end else if (i == 1) begin
        DIN = 32'h88776655; DINEN = 1'b1; expect_chunk(DIN);
      end else begin
        DINEN = 1'b0;
      end
      tick();
      chk("b2b_free", {30'd0, FREE}, exp_free[i]);
      if (i < 8) chk("b2b_contiguous", {31'd0, DOTEN}, 32'd1);
    end
    DINEN = 1'b0;
    chk("b2b_done_doten", {31'd0, DOTEN}, 32'd0);

    // 5. Overflow: third chunk dropped
    RDY = 1'b0;
    DINEN = 1'b1;
    DIN = 32'h14131211; expect_chunk(DIN); tick();
    DIN = 32'h18171615; expect_chunk(DIN); tick();
    chk("ovf_not_yet", {31'd0, OVF}, 32'd0);
    DIN = 32'h1c1b1a19; tick();
    DINEN = 1'b0;
    chk("ovf_set", {31'd0, OVF}, 32'd1);
    chk("ovf_free", {30'd0, FREE}, 32'd0);
    RDY = 1'b1;
    repeat (8) tick();
    chk("ovf_drained_doten", {31'd0, DOTEN}, 32'd0);
    chk("ovf_sticky", {31'd0, OVF}, 32'd1);
    chk("ovf_drained_free", {30'd0, FREE}, 32'd2);

    // 6. Push-while-pop on a full FIFO
    RST = 1'b1; tick(); RST = 1'b0;
    RDY = 1'b0;
    DINEN = 1'b1;
    DIN = 32'h24232221; expect_chunk(DIN); tick();
    DIN = 32'h28272625; expect_chunk(DIN); tick();
    DINEN = 1'b0;
    chk("pwp_full", {30'd0, FREE}, 32'd0);
    RDY = 1'b1;
    repeat (3) tick();
    chk("pwp_at_last", {31'd0, DOTLAST}, 32'd1);
    DIN = 32'h2c2b2a29; DINEN = 1'b1; expect_chunk(DIN); tick();
    DINEN = 1'b0;
    chk("pwp_ovf", {31'd0, OVF}, 32'd0);
    chk("pwp_free", {30'd0, FREE}, 32'd0);
    repeat (8) tick();
    chk("pwp_done_doten", {31'd0, DOTEN}, 32'd0);
    chk("pwp_done_free", {30'd0, FREE}, 32'd2);
    chk("pwp_done_ovf", {31'd0, OVF}, 32'd0);

    tick();
    chk("scoreboard_empty", sb.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sorted_chunk_serializer.md
Name: sorted_chunk_serializer

Overview:
- Sits directly downstream of the odd-even mergesort network. It captures each sorted wide chunk presented with its enable and buffers it in a small chunk FIFO.
- It replays the chunk as a stream of single records, one per cycle, smallest key first, using a valid/ready handshake.
- The sorting network cannot be stalled. This block therefore exports a free-entry count for upstream throttling and flags any chunk lost to overflow.

Parameters:
P_LOG, 4, log2 of records per chunk (chunk = 1<<P_LOG records)
DATW, 64, record width in bits
KEYW, 32, key width (low KEYW bits of a record); carried only, never compared here
DEPTH, 4, chunk FIFO depth in chunks; power of two, >=2
CNTW, 3, width of FREE; must satisfy (1<<CNTW) > DEPTH

Ports:
CLK  input  1  clock, all state on rising edge
RST  input  1  reset, asynchronous, active-high
DIN  input  DATW<<P_LOG  sorted chunk; record r at bits [DATW*(r+1)-1:DATW*r], r=0 smallest
DINEN  input  1  DIN valid this cycle (single-cycle pulse per chunk, no backpressure)
DOT  output  DATW  current output record
DOTEN  output  1  DOT valid
DOTLAST  output  1  DOT is record (1<<P_LOG)-1 of its chunk
RDY  input  1  downstream accepts DOT this cycle
FREE  output  CNTW  number of empty FIFO entries
OVF  output  1  sticky: at least one chunk dropped since reset

Behaviour:
- Reset (async assert, sync-to-CLK release): wr/rd pointers=0, count=0, record index idx=0, OVF=0. Outputs: DOTEN=0, DOTLAST=0, FREE=DEPTH, DOT=don't-care. FIFO storage is not cleared.
- Reset mid-chunk: the partially sent chunk and all buffered chunks are discarded. No record is emitted after release until a new DINEN.
- Storage: DEPTH x (DATW<<P_LOG) register array; binary pointers wrap modulo DEPTH; count in 0..DEPTH.
- Pop event: DOTEN & RDY & (idx==(1<<P_LOG)-1).
- Accept on DINEN: write when count<DEPTH, or when count==DEPTH and a pop event occurs in the same cycle (push-while-pop). The count is then unchanged.
- Drop on DINEN: when count==DEPTH with no pop, the chunk is discarded, OVF<=1 and stays 1 until reset, and FIFO state is unchanged.
- Count update: +1 on accept without pop; -1 on pop without accept; unchanged otherwise.
- DOTEN = (count!=0); registered state only, never combinational from DINEN.
- Latency: a chunk accepted at edge N into an empty FIFO gives DOTEN=1 after edge N, i.e. its first record is visible in cycle N+1.
- DOT = head entry record[idx]: combinational mux from registered head entry and idx, with no extra pipeline stage.
- DOTLAST = DOTEN & (idx==(1<<P_LOG)-1).
- Handshake: a transfer occurs when DOTEN&RDY. On transfer, idx increments; on the last record idx wraps to 0 and the head is popped. While DOTEN&~RDY, DOT, DOTLAST and idx hold stable.
- RDY may be high while DOTEN=0 with no effect. RDY held high gives one record per cycle, and back-to-back chunks produce no bubble between them.
- FREE = DEPTH-count, registered value of the current cycle. It does not anticipate same-cycle events.
- Order is preserved: chunks emerge in arrival order, records within a chunk in ascending index.

Test Plan (P_LOG=2, DATW=8, KEYW=4, DEPTH=2):
1. Reset
   - Stimulus: RST pulse asynchronously mid-cycle.
   - Required: DOTEN=0, DOTLAST=0, FREE=2, OVF=0 immediately, without waiting for a clock edge.
2. Single chunk
   - Stimulus: DINEN pulse with DIN=32'h40_30_20_10, RDY=1.
   - Required: DOT = 10,20,30,40 on the 4 cycles after accept; DOTLAST only with 40; then DOTEN=0 and FREE back to 2.
3. Backpressure
   - Stimulus: same chunk; RDY=0 for 3 cycles after the second record.
   - Required: DOT=20 held, DOTEN=1, DOTLAST=0 throughout the stall; the stream resumes 30,40 with no loss or duplication.
4. Back-to-back
   - Stimulus: two chunks A=44_33_22_11 and B=88_77_66_55 on consecutive cycles, RDY=1.
   - Required: 8 contiguous records 11..88; FREE goes 2→1→0→1→2 at the expected edges.
5. Overflow
   - Stimulus: RDY=0, three DINEN pulses A, B, C.
   - Required: after the third pulse OVF=1, FREE=0. Raising RDY then yields only the records of A and B; OVF stays 1.
6. Push-while-pop
   - Stimulus: FIFO full, RDY=1; DINEN for chunk C asserted in the same cycle as DOTLAST of A.
   - Required: C is accepted, OVF stays 0, FREE stays 0, and output order is A, B, C.
